// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared CPU constants for the MUL/DIV sequencer
// Opcode encodings are shared with the instruction control FSM.
package muldiv_sequencer_pkg;

  localparam int MULDIV_WIDTH = 16;

  localparam logic [3:0] OP_MUL = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - start/busy/done request bus between control FSM and sequencer
// master issues opcodes and operands, slave returns the double-width result.
interface muldiv_sequencer_if
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
);

  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, opcode, op1, op2,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, opcode, op1, op2,
    output busy, done, result_lo, result_hi, div_by_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
// Pair {hi, lo} is {acc_hi, acc_lo} for MUL and {rem, quo} for DIV.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;
  logic             fits;

  always_comb begin
    addend      = lo[0] ? multiplicand : '0;
    sum         = {1'b0, hi} + {1'b0, addend};

    // rem < divisor always holds, so the WIDTH+1-bit difference top bit is the borrow.
    shifted_rem = {hi, lo[WIDTH-1]};
    trial       = shifted_rem - {1'b0, divisor};
    fits        = ~trial[WIDTH];

    if (is_div) begin
      next_hi = fits ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], fits};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative one-bit-per-clock MUL/DIV sequencer with start/busy/done
// Results load only on entry to DONE and hold until the next completion.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             dbz;

  logic             valid_op;
  logic             accept;
  logic             accept_dbz;

  always_comb begin
    valid_op   = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
    accept     = bus.start && valid_op && ((state == IDLE) || (state == DONE));
    accept_dbz = accept && (bus.opcode == OP_DIV) && (bus.op2 == '0);

    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = accept_dbz ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div       (is_div),
    .multiplicand (op_a),
    .divisor      (op_b),
    .hi           (work_hi),
    .lo           (work_lo),
    .next_hi      (step_hi),
    .next_lo      (step_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      res_lo  <= '0;
      res_hi  <= '0;
      dbz     <= 1'b0;
    end else if (accept) begin
      is_div  <= (bus.opcode == OP_DIV);
      op_a    <= bus.op1;
      op_b    <= bus.op2;
      cnt     <= '0;
      work_hi <= '0;
      work_lo <= (bus.opcode == OP_DIV) ? bus.op1 : bus.op2;
      // Divide by zero bypasses CALC, so its result is produced right here.
      if (accept_dbz) begin
        res_lo <= '1;
        res_hi <= bus.op1;
        dbz    <= 1'b1;
      end
    end else if (state == CALC) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
      cnt     <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        res_lo <= step_lo;
        res_hi <= step_hi;
        dbz    <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.result_lo   = res_lo;
  assign bus.result_hi   = res_hi;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
// Directed vector table, hand-written corner sequences and a randomized arithmetic reference.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  muldiv_sequencer_if #(.WIDTH(16)) bus_if ();

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, returns {div_by_zero, hi, lo}
  function automatic logic [32:0] model(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (opc == OP_MUL) begin
      p = 32'(a) * 32'(b);
      return {1'b0, p};
    end
    if (b == 16'd0) return {1'b1, a, 16'hFFFF};
    return {1'b0, a % b, a / b};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus_if.busy && bus_if.done) begin
      checks++;
      errors++;
      $display("FAIL busy_and_done actual=11 required=not both");
    end
  end

  task automatic run_op(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int bcyc, output int dcyc);
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.opcode = opc;
    bus_if.op1    = a;
    bus_if.op2    = b;
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.op1    = 16'($urandom);
    bus_if.op2    = 16'($urandom);
    bus_if.opcode = 4'($urandom);
    lat  = 1;
    bcyc = 0;
    dcyc = 0;
    while (!bus_if.done && lat < 40) begin
      if (bus_if.busy) bcyc++;
      @(negedge clk);
      lat++;
    end
    if (bus_if.done) begin
      dcyc = 1;
      @(negedge clk);
      if (bus_if.done) dcyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [32:0] exp);
    check({tag, "_lo"},  32'(bus_if.result_lo),   32'(exp[15:0]));
    check({tag, "_hi"},  32'(bus_if.result_hi),   32'(exp[31:16]));
    check({tag, "_dbz"}, 32'(bus_if.div_by_zero), 32'(exp[32]));
  endtask

  int          lat, bcyc, dcyc, idx, ndone, done_at;
  logic [31:0] held;
  logic [31:0] seen;
  logic [3:0]  ropc;
  logic [15:0] ra, rb;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.opcode = 4'd0;
    bus_if.op1    = 16'd0;
    bus_if.op2    = 16'd0;

    vecs[0] = '{OP_MUL, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 17};
    vecs[1] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17};
    vecs[2] = '{OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
    vecs[3] = '{OP_DIV, 16'h0055, 16'h0000, 16'hFFFF, 16'h0055, 1'b1, 1};
    vecs[4] = '{OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17};
    vecs[5] = '{OP_DIV, 16'h0005, 16'hFFFF, 16'h0000, 16'h0005, 1'b0, 17};
    vecs[6] = '{OP_MUL, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[7] = '{OP_DIV, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1};

    #12;
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check_result("rst", 33'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].opc, vecs[i].a, vecs[i].b, lat, bcyc, dcyc);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(bcyc), (vecs[i].lat == 1) ? 32'd0 : 32'd16);
      check($sformatf("v%0d_done_width", i), 32'(dcyc), 32'd1);
      check_result($sformatf("v%0d", i), {vecs[i].dbz, vecs[i].hi, vecs[i].lo});
    end
    held = {vecs[7].hi, vecs[7].lo};

    // Unknown opcode in IDLE is ignored
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.opcode = 4'h0;
    bus_if.op1    = 16'd5;
    bus_if.op2    = 16'd5;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("bad_op_busy", 32'(bus_if.busy), 32'd0);
    check("bad_op_done", 32'(bus_if.done), 32'd0);
    check("bad_op_hold", {bus_if.result_hi, bus_if.result_lo}, held);

    // MUL start mid-CALC is ignored; original operands complete with one done
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.opcode = OP_MUL;
    bus_if.op1    = 16'h00AB;
    bus_if.op2    = 16'h0102;
    @(negedge clk);
    bus_if.start = 1'b0;
    idx = 1;
    ndone = 0;
    done_at = 0;
    seen = 32'd0;
    for (int i = 0; i < 30; i++) begin
      if (idx == 5) begin
        bus_if.start  = 1'b1;
        bus_if.opcode = OP_MUL;
        bus_if.op1    = 16'hFFFF;
        bus_if.op2    = 16'hFFFF;
        check("hold_mid_calc", {bus_if.result_hi, bus_if.result_lo}, held);
      end else begin
        bus_if.start = 1'b0;
      end
      if (bus_if.done) begin
        ndone++;
        if (done_at == 0) begin
          done_at = idx;
          seen = {bus_if.result_hi, bus_if.result_lo};
        end
      end
      @(negedge clk);
      idx++;
    end
    check("mid_start_done_count", 32'(ndone), 32'd1);
    check("mid_start_latency", 32'(done_at), 32'd17);
    check("mid_start_result", seen, 32'h0000_AC56);

    // Back-to-back: DIV 9/3 accepted in the DONE cycle of MUL 3*5
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.opcode = OP_MUL;
    bus_if.op1    = 16'd3;
    bus_if.op2    = 16'd5;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat = 1;
    while (!bus_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_done", 32'(bus_if.done), 32'd1);
    check_result("b2b_first", {1'b0, 32'h0000_000F});
    bus_if.start  = 1'b1;
    bus_if.opcode = OP_DIV;
    bus_if.op1    = 16'd9;
    bus_if.op2    = 16'd3;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("b2b_no_bubble_busy", 32'(bus_if.busy), 32'd1);
    check("b2b_done_width", 32'(bus_if.done), 32'd0);
    check("b2b_hold", {bus_if.result_hi, bus_if.result_lo}, 32'h0000_000F);
    lat = 1;
    while (!bus_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", 32'(lat), 32'd17);
    check_result("b2b_second", {1'b0, 16'd0, 16'd3});
    @(negedge clk);

    // Reset during CALC aborts immediately
    @(negedge clk);
    bus_if.start  = 1'b1;
    bus_if.opcode = OP_MUL;
    bus_if.op1    = 16'h1111;
    bus_if.op2    = 16'h0003;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_busy", 32'(bus_if.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus_if.busy), 32'd0);
    check("async_rst_done", 32'(bus_if.done), 32'd0);
    check_result("async_rst", 33'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.done) ndone++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    run_op(OP_MUL, 16'h0100, 16'h0100, lat, bcyc, dcyc);
    check("post_rst_latency", 32'(lat), 32'd17);
    check_result("post_rst", {1'b0, 32'h0001_0000});

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      ropc = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
      ra   = 16'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
      run_op(ropc, ra, rb, lat, bcyc, dcyc);
      check($sformatf("rnd%0d_latency op=%h a=%h b=%h", i, ropc, ra, rb), 32'(lat),
            (ropc == OP_DIV && rb == 16'd0) ? 32'd1 : 32'd17);
      check($sformatf("rnd%0d_done_width", i), 32'(dcyc), 32'd1);
      check_result($sformatf("rnd%0d op=%h a=%h b=%h", i, ropc, ra, rb), model(ropc, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multi-cycle sequencer for the ALU's MUL and DIV opcodes. The instruction control FSM issues an arithmetic opcode with two 16-bit operands. This block latches them and runs a shift-add multiply or a restoring divide, one bit per clock. It reports completion through a start/busy/done handshake and holds the double-width result until the next accepted operation.

## Interface
- WIDTH, 16, operand width; result is 2×WIDTH split into hi/lo halves
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- opcode  in  4  arithmetic opcode; 4'b0001 = MUL, 4'b0011 = DIV, others ignored
- op1  in  WIDTH  multiplicand / dividend; latched on accept
- op2  in  WIDTH  multiplier / divisor; latched on accept
- busy  out  1  high while state = CALC
- done  out  1  one-cycle pulse, high while state = DONE
- result_lo  out  WIDTH  product low half / quotient
- result_hi  out  WIDTH  product high half / remainder
- div_by_zero  out  1  set with done when a DIV had op2 = 0; held with result

## Operation
- Accept: start=1 and opcode ∈ {MUL, DIV} while state ∈ {IDLE, DONE}.
  - Latch op1, op2 and the op kind.
  - Clear cnt and the working registers.
  - Go to CALC.
- Otherwise:
  - start with any other opcode is ignored; no state change.
  - start while in CALC is ignored; there is no queueing.
- States:
  - IDLE → CALC on accept.
  - CALC → DONE when cnt = WIDTH−1 at the clock edge.
  - DONE → CALC on accept, else → IDLE.
- MUL (unsigned):
  - Working pair {acc_hi, acc_lo} starts as {0, op2}.
  - Each CALC cycle: sum = acc_hi + (acc_lo[0] ? op1 : 0), computed WIDTH+1 bits wide.
  - Then {acc_hi, acc_lo} ← {sum, acc_lo} >> 1.
- DIV (unsigned restoring):
  - Working pair {rem, quo} starts as {0, op1}.
  - Each cycle: shift {rem, quo} left by 1, giving trial = shifted rem − op2, computed WIDTH+1 bits wide.
  - If trial ≥ 0: rem ← trial and quo[0] ← 1; else rem keeps the shifted value and quo[0] ← 0.
- Divide by zero:
  - DIV accepted with op2 = 0 skips CALC and goes straight to DONE.
  - Outputs: result_lo = {WIDTH{1}}, result_hi = latched op1, div_by_zero = 1.
- Result registers load only on entry to DONE.
  - They hold through IDLE and through the following CALC.
  - div_by_zero is cleared on every normal completion.
- Arithmetic is unsigned only. The carry/borrow is kept as an extra bit. No overflow is possible: the product fits in 2×WIDTH bits.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, cnt = 0, busy = 0, done = 0.
  - result_lo = result_hi = 0, div_by_zero = 0.
  - All working registers = 0.
- Accept at edge N:
  - busy = 1 for cycles N+1 … N+WIDTH.
  - The WIDTH iteration steps occur at edges N+1 … N+WIDTH.
  - done = 1 and results are valid in the cycle after edge N+WIDTH: WIDTH+1 cycles after the start cycle, 17 at the default width.
- Divide by zero: done in the cycle after edge N, latency 1.
- Back-to-back: start accepted during the DONE cycle puts the block in CALC next. done stays exactly one cycle; there is no idle bubble.
- busy and done are never high together.
- op1, op2 and opcode may change freely after the accept edge.
- Reset asserted mid-CALC aborts the operation. No done is produced, and outputs return to their reset values.

## Structure
- Shared CPU package holds:
  - opcode constants OP_MUL = 4'b0001 and OP_DIV = 4'b0011, reused by the control FSM;
  - the state enum {IDLE, CALC, DONE};
  - the default WIDTH.
- cnt width is $clog2(WIDTH).
- Natural sub-module: muldiv_step. It is purely combinational, performs one add-shift or shift-subtract step, and is selected by op kind. FSM, counter and registers stay in the top.

## Test plan
- MUL op1 = 0x1234, op2 = 0x0010 → after 17 cycles done = 1, result_hi = 0x0001, result_lo = 0x2340, div_by_zero = 0.
- MUL 0xFFFF × 0xFFFF → result_hi = 0xFFFE, result_lo = 0x0001; busy high for exactly 16 cycles.
- DIV 100 ÷ 7 → result_lo = 14, result_hi = 2. Then DIV 0x0055 ÷ 0 → done on the next cycle with result_lo = 0xFFFF, result_hi = 0x0055, div_by_zero = 1.
- Start pulse with opcode 0x0 in IDLE, and MUL start asserted mid-CALC → both ignored; the running op completes with the original operands and a single done.
- Back-to-back: DIV 9 ÷ 3 accepted in the DONE cycle of MUL 3 × 5:
  - first result 0x0000_000F;
  - second result 3 / 0 exactly 17 cycles later;
  - no idle cycle between the two operations.
- rst_n low at cycle 8 of a MUL → all outputs 0 immediately, no done. A new MUL after release completes normally.
